// File: rtl/fs_inst_queue.sv
// Fetch-to-decode instruction buffer: DEPTH-entry circular FIFO of {pc, inst, is_branch}
// that tags each entry sitting in a branch delay slot.
module fs_inst_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             fs_valid,
  input  logic [31:0]      fs_pc,
  input  logic [31:0]      fs_inst,
  input  logic             fs_is_branch,
  output logic             fs_allowin,
  output logic             ds_valid,
  input  logic             ds_allowin,
  output logic [31:0]      ds_pc,
  output logic [31:0]      ds_inst,
  output logic             ds_is_branch,
  output logic             ds_is_ds,
  output logic [CNT_W-1:0] q_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic [DEPTH-1:0] br_mem;
  logic [DEPTH-1:0] ds_mem;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             prev_branch;
  logic             push;
  logic             pop;

  // Handshake: a beat transfers on a side in any cycle where its valid and
  // allowin are both high; valid never depends on allowin. flush cancels both
  // transfers in its cycle without masking fs_allowin.
  assign fs_allowin = (count != CNT_W'(DEPTH));
  assign ds_valid   = (count != '0);
  assign push       = fs_valid & fs_allowin & ~flush;
  assign pop        = ds_valid & ds_allowin & ~flush;
  assign q_count    = count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      prev_branch <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      prev_branch <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr + 1'b1;
        prev_branch <= fs_is_branch;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while count says they are live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fs_pc;
      inst_mem[wr_ptr] <= fs_inst;
      br_mem[wr_ptr]   <= fs_is_branch;
      ds_mem[wr_ptr]   <= prev_branch;
    end
  end

  assign ds_pc        = ds_valid ? pc_mem[rd_ptr]   : 32'h0;
  assign ds_inst      = ds_valid ? inst_mem[rd_ptr] : 32'h0;
  assign ds_is_branch = ds_valid ? br_mem[rd_ptr]   : 1'b0;
  assign ds_is_ds     = ds_valid ? ds_mem[rd_ptr]   : 1'b0;

endmodule

// File: tb/tb_fs_inst_queue.sv
// Directed bench for fs_inst_queue: reset, fill/drain, delay-slot tagging,
// full-queue pop/push, flush and a wrap-around stream against an expected queue.
module tb_fs_inst_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk;
  logic             resetn;
  logic             flush;
  logic             fs_valid;
  logic [31:0]      fs_pc;
  logic [31:0]      fs_inst;
  logic             fs_is_branch;
  logic             fs_allowin;
  logic             ds_valid;
  logic             ds_allowin;
  logic [31:0]      ds_pc;
  logic [31:0]      ds_inst;
  logic             ds_is_branch;
  logic             ds_is_ds;
  logic [CNT_W-1:0] q_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  fs_inst_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .fs_valid(fs_valid), .fs_pc(fs_pc), .fs_inst(fs_inst), .fs_is_branch(fs_is_branch),
    .fs_allowin(fs_allowin), .ds_valid(ds_valid), .ds_allowin(ds_allowin),
    .ds_pc(ds_pc), .ds_inst(ds_inst), .ds_is_branch(ds_is_branch), .ds_is_ds(ds_is_ds),
    .q_count(q_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // occupancy bound monitor
  always @(negedge clk) begin
    if (resetn) begin
      n_cmp++;
      if (q_count > CNT_W'(DEPTH)) begin
        n_err++;
        $display("FAIL count_bound: q_count=%0d limit=%0d", q_count, DEPTH);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fs_valid     = 1'b0;
    fs_pc        = '0;
    fs_inst      = '0;
    fs_is_branch = 1'b0;
    ds_allowin   = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic push_beat(input logic [31:0] pc, input logic br);
    fs_valid     = 1'b1;
    fs_pc        = pc;
    fs_inst      = ~pc;
    fs_is_branch = br;
    step();
    fs_valid     = 1'b0;
    fs_is_branch = 1'b0;
  endtask

  task automatic test_reset();
    resetn     = 1'b0;
    idle();
    fs_valid   = 1'b1;
    fs_pc      = 32'hDEAD_0000;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (ds_valid !== 1'b0 || q_count !== 3'd0 || fs_allowin !== 1'b1 || ds_pc !== 32'h0) begin
        n_err++;
        $display("FAIL reset_hold: ds_valid=%b q_count=%0d fs_allowin=%b ds_pc=%h want 0/0/1/0",
                 ds_valid, q_count, fs_allowin, ds_pc);
      end
    end
    idle();
    resetn = 1'b1;
    step();
    n_cmp++;
    if (ds_valid !== 1'b0 || q_count !== 3'd0 || fs_allowin !== 1'b1 || ds_is_ds !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: ds_valid=%b q_count=%0d fs_allowin=%b ds_is_ds=%b want 0/0/1/0",
               ds_valid, q_count, fs_allowin, ds_is_ds);
    end
  endtask

  task automatic test_fill_drain();
    logic [31:0] exp_pc;
    idle();
    for (int i = 0; i < 4; i++) push_beat(32'hBFC0_0000 + 32'(4 * i), 1'b0);
    n_cmp++;
    if (q_count !== 3'd4 || fs_allowin !== 1'b0) begin
      n_err++;
      $display("FAIL fill_full: q_count=%0d fs_allowin=%b want 4/0", q_count, fs_allowin);
    end
    push_beat(32'hBFC0_0010, 1'b0);
    n_cmp++;
    if (q_count !== 3'd4 || ds_pc !== 32'hBFC0_0000) begin
      n_err++;
      $display("FAIL fill_refuse: q_count=%0d head=%h want 4/bfc00000", q_count, ds_pc);
    end
    ds_allowin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'hBFC0_0000 + 32'(4 * i);
      n_cmp++;
      if (ds_valid !== 1'b1 || ds_pc !== exp_pc || ds_inst !== ~exp_pc) begin
        n_err++;
        $display("FAIL drain_order[%0d]: valid=%b pc=%h inst=%h want 1/%h/%h",
                 i, ds_valid, ds_pc, ds_inst, exp_pc, ~exp_pc);
      end
      step();
    end
    ds_allowin = 1'b0;
    n_cmp++;
    if (q_count !== 3'd0 || ds_valid !== 1'b0 || ds_pc !== 32'h0) begin
      n_err++;
      $display("FAIL drain_empty: q_count=%0d ds_valid=%b ds_pc=%h want 0/0/0", q_count, ds_valid, ds_pc);
    end
  endtask

  task automatic test_delay_slot();
    logic [2:0] exp_ds;
    logic [2:0] exp_br;
    idle();
    // beq, add, or
    push_beat(32'h100, 1'b1);
    push_beat(32'h104, 1'b0);
    push_beat(32'h108, 1'b0);
    exp_ds = 3'b010;
    exp_br = 3'b001;
    ds_allowin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ds_pc !== 32'h100 + 32'(4 * i) || ds_is_ds !== exp_ds[i] || ds_is_branch !== exp_br[i]) begin
        n_err++;
        $display("FAIL ds_beq[%0d]: pc=%h is_ds=%b is_br=%b want %h/%b/%b",
                 i, ds_pc, ds_is_ds, ds_is_branch, 32'h100 + 32'(4 * i), exp_ds[i], exp_br[i]);
      end
      step();
    end
    ds_allowin = 1'b0;
    // jr, jal, nop
    push_beat(32'h200, 1'b1);
    push_beat(32'h204, 1'b1);
    push_beat(32'h208, 1'b0);
    exp_ds = 3'b110;
    ds_allowin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ds_pc !== 32'h200 + 32'(4 * i) || ds_is_ds !== exp_ds[i]) begin
        n_err++;
        $display("FAIL ds_jr_jal[%0d]: pc=%h is_ds=%b want %h/%b",
                 i, ds_pc, ds_is_ds, 32'h200 + 32'(4 * i), exp_ds[i]);
      end
      step();
    end
    // branch tag survives idle cycles and the branch's own pop
    push_beat(32'h300, 1'b1);
    step();
    step();
    ds_allowin = 1'b0;
    push_beat(32'h304, 1'b0);
    n_cmp++;
    if (ds_valid !== 1'b1 || ds_pc !== 32'h304 || ds_is_ds !== 1'b1) begin
      n_err++;
      $display("FAIL ds_persist: valid=%b pc=%h is_ds=%b want 1/00000304/1", ds_valid, ds_pc, ds_is_ds);
    end
    ds_allowin = 1'b1;
    step();
    ds_allowin = 1'b0;
  endtask

  task automatic test_full_pop_push();
    idle();
    for (int i = 0; i < 4; i++) push_beat(32'h400 + 32'(4 * i), 1'b0);
    fs_valid   = 1'b1;
    fs_pc      = 32'h410;
    fs_inst    = ~32'h410;
    ds_allowin = 1'b1;
    step();
    n_cmp++;
    if (q_count !== 3'd3 || ds_pc !== 32'h404) begin
      n_err++;
      $display("FAIL full_pop_only: q_count=%0d head=%h want 3/00000404", q_count, ds_pc);
    end
    step();
    n_cmp++;
    if (q_count !== 3'd3 || ds_pc !== 32'h408) begin
      n_err++;
      $display("FAIL pop_push: q_count=%0d head=%h want 3/00000408", q_count, ds_pc);
    end
    fs_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ds_valid !== 1'b1 || ds_pc !== 32'h408 + 32'(4 * i)) begin
        n_err++;
        $display("FAIL pop_push_order[%0d]: valid=%b pc=%h want 1/%h", i, ds_valid, ds_pc, 32'h408 + 32'(4 * i));
      end
      step();
    end
    n_cmp++;
    if (q_count !== 3'd0) begin
      n_err++;
      $display("FAIL pop_push_empty: q_count=%0d want 0", q_count);
    end
    ds_allowin = 1'b0;
  endtask

  task automatic test_flush();
    idle();
    push_beat(32'h500, 1'b0);
    push_beat(32'h504, 1'b0);
    push_beat(32'h508, 1'b1);
    flush      = 1'b1;
    fs_valid   = 1'b1;
    fs_pc      = 32'h50C;
    ds_allowin = 1'b1;
    #1;
    n_cmp++;
    if (fs_allowin !== 1'b1) begin
      n_err++;
      $display("FAIL flush_allowin: fs_allowin=%b want 1", fs_allowin);
    end
    step();
    idle();
    n_cmp++;
    if (q_count !== 3'd0 || ds_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_clear: q_count=%0d ds_valid=%b want 0/0", q_count, ds_valid);
    end
    push_beat(32'h600, 1'b0);
    n_cmp++;
    if (q_count !== 3'd1 || ds_pc !== 32'h600 || ds_is_ds !== 1'b0) begin
      n_err++;
      $display("FAIL flush_after: q_count=%0d pc=%h is_ds=%b want 1/00000600/0", q_count, ds_pc, ds_is_ds);
    end
    ds_allowin = 1'b1;
    step();
    ds_allowin = 1'b0;
  endtask

  task automatic test_wrap();
    int idx = 0;
    int got = 0;
    int cyc = 0;
    logic pop_now;
    logic push_now;
    idle();
    exp_q.delete();
    while (got < 20 && cyc < 400) begin
      fs_valid   = (idx < 20);
      fs_pc      = 32'h1000 + 32'(4 * idx);
      fs_inst    = ~(32'h1000 + 32'(4 * idx));
      ds_allowin = 1'($urandom_range(0, 1));
      #1;
      n_cmp++;
      if (q_count !== CNT_W'(exp_q.size()) || ds_valid !== (exp_q.size() != 0) ||
          fs_allowin !== (exp_q.size() != DEPTH)) begin
        n_err++;
        $display("FAIL wrap_status: q_count=%0d valid=%b allowin=%b want count %0d",
                 q_count, ds_valid, fs_allowin, exp_q.size());
      end
      if (exp_q.size() != 0) begin
        n_cmp++;
        if (ds_pc !== exp_q[0]) begin
          n_err++;
          $display("FAIL wrap_order: pc=%h want %h", ds_pc, exp_q[0]);
        end
      end
      pop_now  = ds_allowin && (exp_q.size() != 0);
      push_now = fs_valid && (exp_q.size() < DEPTH);
      if (pop_now) begin
        void'(exp_q.pop_front());
        got++;
      end
      if (push_now) begin
        exp_q.push_back(fs_pc);
        idx++;
      end
      step();
      cyc++;
    end
    idle();
    n_cmp++;
    if (got != 20) begin
      n_err++;
      $display("FAIL wrap_timeout: received=%0d want 20", got);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_delay_slot();
    test_full_pop_push();
    test_flush();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fs_inst_queue.md
Name: fs_inst_queue

Overview:
- Instruction buffer between the fetch stage (after pre-decode) and the decode stage.
- Accepts fetched {pc, inst, is_branch} beats under a valid/allowin handshake and stores them in a DEPTH-entry circular FIFO.
- Tags each entry that sits in a branch delay slot.
- Presents the oldest entry to decode; a flush discards all buffered instructions.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- flush  input  1  discard all entries and delay-slot tracking (exception/eret).
- fs_valid  input  1  fetch presents a valid instruction.
- fs_pc  input  32  PC of the presented instruction.
- fs_inst  input  32  instruction word.
- fs_is_branch  input  1  pre-decoded branch/jump flag for fs_inst.
- fs_allowin  output  1  queue can accept a beat this cycle.
- ds_valid  output  1  head entry valid toward decode.
- ds_allowin  input  1  decode accepts the head entry this cycle.
- ds_pc  output  32  head PC.
- ds_inst  output  32  head instruction.
- ds_is_branch  output  1  head branch flag.
- ds_is_ds  output  1  head entry is a delay-slot instruction.
- q_count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (resetn low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, prev_branch=0. Outputs: ds_valid=0, ds_pc/ds_inst=0, ds_is_branch=0, ds_is_ds=0, q_count=0, fs_allowin=1. Storage array contents are don't-care. Deasserting resetn mid-operation loses all entries.
- fs_allowin = (count != DEPTH). No same-cycle pop bypass: a full queue refuses a push even while popping.
- push = fs_valid & fs_allowin & ~flush.
- pop = ds_valid & ds_allowin & ~flush.
- ds_valid = (count != 0). No write-through: a beat pushed in cycle N is visible at the head at the earliest in cycle N+1.
- Head outputs are a combinational read of entry[rd_ptr]. When count==0, ds_pc, ds_inst, ds_is_branch and ds_is_ds are forced to 0.
- On push:
  - entry[wr_ptr] <= {fs_pc, fs_inst, fs_is_branch, prev_branch}.
  - wr_ptr <= wr_ptr+1 mod DEPTH.
  - prev_branch <= fs_is_branch.
- On pop: rd_ptr <= rd_ptr+1 mod DEPTH.
- count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop: count unchanged.
  - neither: count unchanged.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Full and empty are distinguished only by count.
- Delay-slot rule: an entry is tagged is_ds=1 iff the immediately preceding pushed instruction had is_branch=1.
  - A branch in a delay slot (branch followed by branch) gives the second branch is_ds=1, and its successor is also tagged is_ds=1.
  - prev_branch persists across idle cycles and across pops.
- flush (priority over push and pop in the same cycle): wr_ptr=rd_ptr=0, count=0, prev_branch=0. ds_valid=0 from the next cycle. fs_allowin is not gated combinationally by flush; the push is simply suppressed.
- q_count = count (registered value).
- Overflow/underflow are impossible by construction. The bench asserts count never exceeds DEPTH.

Test Plan:
- Reset: hold resetn=0 with fs_valid=1 -> no pushes. ds_valid=0, q_count=0, fs_allowin=1 throughout; these values hold the cycle after release with no stimulus.
- Fill/drain: ds_allowin=0; push pc 0xBFC00000,+4,+8,+C -> q_count=4 and fs_allowin=0 after the 4th push, 5th beat is not accepted. Then ds_allowin=1 -> heads appear in order 0xBFC00000..0xBFC0000C, q_count reaches 0, ds_valid=0.
- Delay slot: push beq (is_branch=1) at 0x100, then add at 0x104, then or at 0x108 -> ds_is_ds sequence 0,1,0. Push jr then jal then nop -> 0,1,1.
- Full plus simultaneous pop/push: queue full, ds_allowin=1, fs_valid=1 -> that cycle pops only, q_count 4->3. Next cycle push and pop together -> q_count stays 3, order preserved.
- Flush: 3 entries buffered with a branch last, assert flush together with fs_valid=1 and ds_allowin=1 -> next cycle q_count=0, ds_valid=0, and the flushed-cycle beat is absent. The next pushed instruction has ds_is_ds=0.
- Wrap-around: stream 20 sequential PCs with random ds_allowin stalls -> output PC sequence is identical to the input sequence, and q_count always ≤4.
